// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED running-light control path and its shifter.
package led_ctrl_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DB_CYCLES_DEF = CLK_HZ / 100;   // 10 ms debounce window
    localparam int DIV_SLOW_DEF  = 8_388_608;
    localparam int DIV_FAST_DEF  = 2_097_152;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: 2-FF sync, stability-window debounce, one-cycle press pulse.
// Press pulse appears 2 + DB_CYCLES + 1 cycles after a clean falling edge; release is silent.
module key_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            // Any cycle where the input agrees with the stable state restarts the window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_tick_ctrl.sv
// Front-end for the LED shifter: debounced keys, run/pause toggle, direction and step strobe.
// step is a one-cycle strobe every DIV cycles while running, or one per KEY[1] press while paused.
module key_tick_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DIV_SLOW  = DIV_SLOW_DEF,
    parameter int DIV_FAST  = DIV_FAST_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] KEY,
    input  logic [1:0] SW,
    output logic       run,
    output logic       dir,
    output logic       step,
    output logic [1:0] key_press
);

    localparam int PW = $clog2(DIV_SLOW);
    localparam logic [PW-1:0] LAST_SLOW = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0] LAST_FAST = PW'(DIV_FAST - 1);

    logic [1:0]    sw_s1;
    logic [1:0]    sw_s2;
    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] pre_last;

    for (genvar i = 0; i < 2; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_key_debounce (
            .clk   (CLOCK_50),
            .reset (reset),
            .key_n (KEY[i]),
            .press (key_press[i])
        );
    end

    // SW[0] high means DIR_LEFT, matching the shifter's encoding.
    assign dir = sw_s2[0];

    always_comb begin
        pre_last = sw_s2[1] ? LAST_FAST : LAST_SLOW;
    end

    // The >= compare lets a switch to the shorter period wrap immediately.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            run     <= 1'b1;
            step    <= 1'b0;
            pre_cnt <= '0;
        end else begin
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
            run   <= run ^ key_press[0];
            if (run) begin
                if (pre_cnt >= pre_last) begin
                    pre_cnt <= '0;
                    step    <= 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + PW'(1);
                    step    <= 1'b0;
                end
            end else begin
                pre_cnt <= '0;
                step    <= key_press[1];
            end
        end
    end

endmodule

// File: tb/tb_key_tick_ctrl.sv
// Timeline bench: expected step/key_press events are queued by cycle and matched as they appear.
module tb_key_tick_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] key;
    logic [1:0] sw;
    logic       run;
    logic       dir;
    logic       step;
    logic [1:0] key_press;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [2:0] val;   // {step, key_press[1], key_press[0]}
    } ev_t;

    ev_t exp_q[$];

    localparam logic [2:0] EV_STEP = 3'b100;
    localparam logic [2:0] EV_KP1  = 3'b010;
    localparam logic [2:0] EV_KP0  = 3'b001;

    key_tick_ctrl #(
        .DB_CYCLES (4),
        .DIV_SLOW  (16),
        .DIV_FAST  (4)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .KEY       (key),
        .SW        (sw),
        .run       (run),
        .dir       (dir),
        .step      (step),
        .key_press (key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic void expect_ev(input int c, input logic [2:0] val);
        ev_t e;
        int  i = 0;
        e.cyc = c;
        e.val = val;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endfunction

    function automatic void expect_steps(input int first, input int period, input int n);
        for (int k = 0; k < n; k++) expect_ev(first + k * period, EV_STEP);
    endfunction

    // Leaves the caller 1 time unit after the edge that made cyc == c.
    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [2:0] obs_v;
    ev_t        obs_e;

    always @(negedge clk) begin
        obs_v = {step, key_press};
        if ((|obs_v) === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", int'(obs_v), 0);
            end else begin
                obs_e = exp_q.pop_front();
                check_eq("event_cycle", cyc, obs_e.cyc);
                check_eq("event_value", int'(obs_v), int'(obs_e.val));
            end
        end
    end

    initial begin
        reset = 1'b1;
        key   = 2'b11;
        sw    = 2'b00;

        at_cyc(2);
        check_eq("rst_run", int'(run), 1);
        check_eq("rst_dir", int'(dir), 0);
        check_eq("rst_step", int'(step), 0);
        check_eq("rst_key_press", int'(key_press), 0);

        // Release after edge 3; slow steps every 16 cycles starting 16 edges later.
        at_cyc(3);
        reset = 1'b0;
        expect_steps(19, 16, 3);

        // Two-cycle bounce on KEY[0] must be rejected.
        at_cyc(40);
        key[0] = 1'b0;
        at_cyc(42);
        key[0] = 1'b1;
        at_cyc(48);
        check_eq("bounce_run", int'(run), 1);

        // Clean press pauses.
        at_cyc(50);
        key[0] = 1'b0;
        expect_ev(57, EV_KP0);
        at_cyc(57);
        check_eq("pre_pause_run", int'(run), 1);
        at_cyc(58);
        check_eq("pause_run", int'(run), 0);
        at_cyc(60);
        key[0] = 1'b1;

        // Single step while paused.
        at_cyc(70);
        key[1] = 1'b0;
        expect_ev(77, EV_KP1);
        expect_ev(78, EV_STEP);
        at_cyc(80);
        key[1] = 1'b1;

        // Resume: first step 16 cycles after run rises at edge 98.
        at_cyc(90);
        key[0] = 1'b0;
        expect_ev(97, EV_KP0);
        expect_steps(114, 16, 3);
        at_cyc(98);
        check_eq("resume_run", int'(run), 1);
        at_cyc(100);
        key[0] = 1'b1;

        // KEY[1] while running produces only its press pulse.
        at_cyc(110);
        key[1] = 1'b0;
        expect_ev(117, EV_KP1);
        at_cyc(120);
        key[1] = 1'b1;

        // Counter is 10 after edge 156; switch to fast mid-count.
        at_cyc(156);
        sw[1] = 1'b1;
        expect_steps(159, 4, 4);

        // Back to slow just after the step at 171; fast compare still applies at edge 174.
        at_cyc(172);
        sw[1] = 1'b0;
        expect_steps(187, 16, 2);

        // Press lands on the terminal count: step still emitted, then pause.
        at_cyc(211);
        key[0] = 1'b0;
        expect_ev(218, EV_KP0);
        expect_ev(219, EV_STEP);
        at_cyc(219);
        check_eq("tc_pause_run", int'(run), 0);
        at_cyc(221);
        key[0] = 1'b1;

        at_cyc(240);
        key[0] = 1'b0;
        expect_ev(247, EV_KP0);
        expect_steps(264, 16, 3);
        at_cyc(248);
        check_eq("tc_resume_run", int'(run), 1);
        at_cyc(250);
        key[0] = 1'b1;

        // Direction follows SW[0] two edges later.
        at_cyc(285);
        sw[0] = 1'b1;
        at_cyc(286);
        check_eq("dir_lag", int'(dir), 0);
        at_cyc(287);
        check_eq("dir_follow", int'(dir), 1);

        // Pause, then reset while paused with KEY[1] held through reset.
        at_cyc(300);
        key[0] = 1'b0;
        expect_ev(307, EV_KP0);
        at_cyc(308);
        check_eq("pause2_run", int'(run), 0);
        at_cyc(310);
        key[0] = 1'b1;
        at_cyc(318);
        key[1] = 1'b0;
        at_cyc(320);
        reset = 1'b1;
        at_cyc(321);
        reset = 1'b0;
        check_eq("midrst_run", int'(run), 1);
        check_eq("midrst_dir", int'(dir), 0);
        check_eq("midrst_step", int'(step), 0);
        expect_ev(328, EV_KP1);
        expect_steps(337, 16, 3);
        at_cyc(323);
        check_eq("midrst_dir_resync", int'(dir), 1);
        at_cyc(340);
        key[1] = 1'b1;

        at_cyc(375);
        check_eq("pending_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
